// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and shared constants for the instruction memory loader
package imem_loader_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_COUNT = 3'd1;
  localparam state_t S_HI    = 3'd2;
  localparam state_t S_LO    = 3'd3;
  localparam state_t S_CSUM  = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  localparam state_t S_ERR   = 3'd6;
  localparam logic [7:0] DEF_HEADER = 8'hA5;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int MAX_WORDS = 2 ** DEF_ADDRESS_WIDTH;
endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: assembles hi/lo bytes into an instruction word and registers the RAM write
module loader_word_pack
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     hi_take,
  input  logic                     lo_take,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     hi_bad,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_data
);
  localparam int HW = DATA_WIDTH - 8;
  logic [HW-1:0] hi;
  // any bit above the word's upper field makes the image invalid
  assign hi_bad = (in_data >> HW) != 8'd0;
  always_ff @(posedge clock)
    if (reset) begin
      hi <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      imem_we <= lo_take;
      if (hi_take) hi <= in_data[HW-1:0];
      if (lo_take) begin
        imem_addr <= addr;
        imem_data <= {hi, in_data};
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the instruction RAM, holding the CPU in reset until an image lands.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter logic [7:0] HEADER = DEF_HEADER
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH:0]   load_count
);
  localparam logic [ADDRESS_WIDTH:0] FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  state_t state, next;
  logic [ADDRESS_WIDTH:0] n;
  logic hi_bad, hi_take, lo_take, last;
  assign hi_take = in_valid && state == S_HI && !hi_bad;
  assign lo_take = in_valid && state == S_LO;
  assign last = load_count + ONE == n;
  assign done = state == S_DONE;
  assign error = state == S_ERR;
  assign cpu_hold = state != S_DONE;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
  logic [7:0] csum;
  always_ff @(posedge clock)
    if (reset) csum <= '0;
    else if (in_valid)
      csum <= state == S_COUNT ? in_data : (state == S_HI || state == S_LO) ? csum ^ in_data : csum;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  always_comb begin
    next = state;
    if (in_valid)
      case (state)
        S_IDLE, S_DONE, S_ERR: next = in_data == HEADER ? S_COUNT : state;
        S_COUNT: next = S_HI;
        S_HI: next = hi_bad ? S_ERR : S_LO;
        S_LO: next = last ? S_FIN : S_HI;
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: next = in_data == csum ? S_DONE : S_ERR;
`endif
        default: next = S_IDLE;
      endcase
  end
  // entering COUNT always comes from a header, so it doubles as the load-start strobe
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      n <= '0;
      load_count <= '0;
    end else begin
      state <= next;
      if (in_valid && state == S_COUNT) n <= in_data == 8'd0 ? FULL : (ADDRESS_WIDTH + 1)'(in_data);
      if (next == S_COUNT) load_count <= '0;
      else if (lo_take) load_count <= load_count + ONE;
    end
  loader_word_pack #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pack (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .hi_take(hi_take),
    .lo_take(lo_take),
    .addr(load_count[ADDRESS_WIDTH-1:0]),
    .hi_bad(hi_bad),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_data(imem_data)
  );
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that fills the 15-bit x 256 instruction memory that the processor fetches from.
- Sits between a UART byte receiver (outside this block) and the write port of the instruction RAM.
- Holds the processor in reset (cpu_hold) while a load runs. Releases it only after a complete, valid image has been written.

Parameters:
- DATA_WIDTH, 15, instruction word width; the upper byte carries DATA_WIDTH-8 bits.
- ADDRESS_WIDTH, 8, instruction memory address width; maximum image is 2**ADDRESS_WIDTH words.
- HEADER, 8'hA5, sync byte that starts a load.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  one received byte is present this cycle. The source cannot stall; at most one byte per clock.
- in_data  input  8  received byte.
- imem_we  output  1  single-cycle write strobe to the instruction RAM.
- imem_addr  output  ADDRESS_WIDTH  write address.
- imem_data  output  DATA_WIDTH  write data.
- cpu_hold  output  1  processor reset request; high unless a load has completed.
- done  output  1  last load completed successfully.
- error  output  1  last load aborted.
- load_count  output  ADDRESS_WIDTH+1  words written in the current or last load.

Behaviour:
- Frame format: HEADER, N, then N words, then a checksum byte when LOADER_CHECKSUM_EN is defined.
  - N = 0 means 2**ADDRESS_WIDTH words.
  - Each word is hi byte then lo byte: word = {hi[DATA_WIDTH-9:0], lo}.
- Reset values: state IDLE, imem_we 0, imem_addr 0, imem_data 0, cpu_hold 1, done 0, error 0, load_count 0.
- States: IDLE, COUNT, HI, LO, CSUM, DONE, ERR. Transitions happen only on cycles with in_valid = 1.
- IDLE:
  - HEADER -> COUNT.
  - Any other byte is discarded.
- COUNT:
  - Latch N and clear load_count; next write address is 0.
  - Clear done and error; cpu_hold = 1.
  - -> HI.
- HI:
  - Any of in_data[7:DATA_WIDTH-8] set -> ERR.
  - Otherwise latch the low DATA_WIDTH-8 bits and go to LO.
- LO, on accepting the byte:
  - The next cycle drives imem_we = 1 for exactly one cycle, with imem_addr = load_count[ADDRESS_WIDTH-1:0] and imem_data = {hi, lo}.
  - load_count increments in that same cycle.
  - Latency: lo byte accepted at cycle t -> write strobe at t+1.
- Word accounting, after accepting the lo byte:
  - If this is word N -> CSUM (macro on) or DONE (macro off).
  - Otherwise -> HI.
  - Back-to-back bytes at one per clock are sustained. The strobe for word k overlaps reception of word k+1's hi byte.
- DONE:
  - done = 1, cpu_hold = 0.
  - HEADER restarts a load: -> COUNT, cpu_hold returns to 1 next cycle.
  - Other bytes are ignored.
- ERR:
  - error = 1, cpu_hold = 1, imem_we = 0.
  - HEADER -> COUNT; other bytes are ignored.
- imem_addr and imem_data hold their last values when imem_we = 0.
- A 256-word load writes addresses 0..255. load_count ends at 256; the address never wraps mid-load.
- Reset mid-load: returns to IDLE with cpu_hold = 1. Words already written to RAM are not cleared.
- A HEADER value seen inside a frame is data, not a resync.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running XOR covers the N byte and every hi and lo byte.
  - State CSUM compares the next byte against it: match -> DONE, mismatch -> ERR.
  - Words already written remain in RAM, but cpu_hold stays 1.
- Not defined:
  - No CSUM state and no XOR register.
  - The last lo byte goes directly to DONE; there is no trailing byte.

Decomposition:
- Shared package holds:
  - the loader state enum;
  - the HEADER default constant;
  - the frame-length helper constant MAX_WORDS = 2**ADDRESS_WIDTH.
- One natural sub-module, loader_word_pack: hi/lo byte assembly, the hi-byte range check, and the registered write strobe.

Test Plan:
- A5 02 01 23 00 45, macro off -> strobes addr0 = 15'h0123 and addr1 = 15'h0045, one cycle after each lo byte; done = 1, cpu_hold 1 -> 0, load_count = 2.
- A5 01 80 00 -> error = 1, cpu_hold = 1, no imem_we.
- Macro on: A5 01 12 34 then checksum 0x27 (01^12^34) -> done. Same frame with checksum 0x28 -> error = 1, word still written at addr 0.
- A5 00 followed by 512 bytes at one per clock -> 256 strobes at addrs 0..255, load_count = 256, done. Then A5 01 00 07 -> cpu_hold reasserts, addr0 = 15'h0007.
- Reset asserted after the 3rd word of an N = 5 load -> next cycle state IDLE, cpu_hold = 1, imem_we = 0, load_count = 0. Bytes 11 22 before a new A5 are ignored.
- Garbage 00 FF 5A then A5 01 7F FF -> garbage ignored; addr0 = 15'h7FFF written, done = 1.
